cfi_violation_ctrl: RTL and testbench

- Controller sitting between the commit-stage CFI NOP checkers (call checker, return checker) and the commit exception path.
- Holds the CFI mode register and drives the checker enable.
- Round-robin arbitrates violation requests from the checkers and presents one exception at a time with a valid/ready handshake.
- Keeps a saturating violation counter.

---
 rtl/cfi_violation_ctrl_pkg.sv | 29 ++
 rtl/cfi_violation_ctrl_rr_arbiter.sv | 31 +++
 rtl/cfi_violation_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cfi_violation_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cfi_violation_ctrl_pkg.sv
// Shared types for the CFI violation controller: mode encoding, checker
// source indices, controller FSM states and the reported exception cause.
package cfi_violation_ctrl_pkg;

    typedef enum logic [1:0] {
        CFI_OFF     = 2'd0,
        CFI_COUNT   = 2'd1,
        CFI_ENFORCE = 2'd2,
        CFI_RSVD    = 2'd3
    } cfi_mode_e;

    localparam int CFI_SRC_CALL = 0;
    localparam int CFI_SRC_RET  = 1;

    // Cause value of riscv::BREAKPOINT.
    localparam int unsigned CFI_CAUSE_BREAKPOINT = 32'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REPORT = 2'd1,
        ST_DRAIN  = 2'd2
    } ctrl_state_e;

    // The reserved encoding behaves exactly like ENFORCE.
    function automatic logic mode_enforce(input cfi_mode_e m);
        return (m == CFI_ENFORCE) || (m == CFI_RSVD);
    endfunction

endpackage

// File: rtl/cfi_violation_ctrl_rr_arbiter.sv
// Round-robin picker: grants the first set request at or after the pointer,
// wrapping around the source vector.
module cfi_rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/cfi_violation_ctrl.sv
// CFI violation controller: mode register, saturating violation counter and
// round-robin reporting of checker violations to the commit exception path.
module cfi_violation_ctrl
    import cfi_violation_ctrl_pkg::*;
#(
    parameter  int NR_SOURCES   = 2,
    parameter  int CNT_WIDTH    = 16,
    parameter  int DRAIN_CYCLES = 4,
    parameter  int XLEN         = 64,
    localparam int SRC_W        = (NR_SOURCES > 1) ? $clog2(NR_SOURCES) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             csr_we_i,
    input  logic [1:0]                       csr_wdata_i,
    output logic [1:0]                       mode_o,
    output logic                             csr_en_o,
    input  logic [NR_SOURCES-1:0]            src_req_i,
    input  logic [NR_SOURCES-1:0][XLEN-1:0]  src_tval_i,
    input  logic                             flush_i,
    output logic                             ex_valid_o,
    input  logic                             ex_ready_i,
    output logic [XLEN-1:0]                  ex_cause_o,
    output logic [XLEN-1:0]                  ex_tval_o,
    output logic [SRC_W-1:0]                 ex_src_o,
    output logic [CNT_WIDTH-1:0]             viol_cnt_o,
    output logic                             cnt_sat_o,
    output logic                             busy_o
);

    localparam int DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    cfi_mode_e                        mode_q;
    logic                             en_q;
    logic [CNT_WIDTH-1:0]             cnt_q, cnt_d;
    logic                             sat_q, sat_d;
    ctrl_state_e                      state_q, state_d;
    logic [DRN_W-1:0]                 drain_q, drain_d;
    logic [NR_SOURCES-1:0]            pend_q, pend_d;
    logic [SRC_W-1:0]                 ptr_q, ptr_d;
    logic [NR_SOURCES-1:0][XLEN-1:0]  tval_q, tval_d;
    logic [XLEN-1:0]                  ex_tval_q, ex_tval_d;
    logic [XLEN-1:0]                  ex_cause_q, ex_cause_d;
    logic [SRC_W-1:0]                 ex_src_q, ex_src_d;
    logic [CNT_WIDTH:0]               cnt_sum;
    logic [NR_SOURCES-1:0]            new_req;
    logic                             clear_all;

    logic [NR_SOURCES-1:0] arb_gnt;
    logic [SRC_W-1:0]      arb_idx;
    logic                  arb_any;

    cfi_rr_arbiter #(.N(NR_SOURCES)) u_arb (
        .req_i (pend_q),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Counting runs in every FSM state; only the mode gates it.
    always_comb begin
        cnt_sum = {1'b0, cnt_q};
        if (mode_q != CFI_OFF) begin
            for (int i = 0; i < NR_SOURCES; i++) begin
                cnt_sum = cnt_sum + {{CNT_WIDTH{1'b0}}, src_req_i[i]};
            end
        end
        if (cnt_sum >= {1'b0, CNT_MAX}) begin
            cnt_d = CNT_MAX;
            sat_d = 1'b1;
        end else begin
            cnt_d = cnt_sum[CNT_WIDTH-1:0];
            sat_d = sat_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        ptr_d      = ptr_q;
        tval_d     = tval_q;
        ex_tval_d  = ex_tval_q;
        ex_cause_d = ex_cause_q;
        ex_src_d   = ex_src_q;
        pend_d     = pend_q;
        clear_all  = 1'b0;

        // Requests during DRAIN belong to instructions that are being flushed.
        new_req = (mode_enforce(mode_q) && state_q != ST_DRAIN) ? src_req_i : '0;
        for (int i = 0; i < NR_SOURCES; i++) begin
            if (new_req[i]) tval_d[i] = src_tval_i[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    ex_tval_d  = tval_q[arb_idx];
                    ex_src_d   = arb_idx;
                    ex_cause_d = XLEN'(CFI_CAUSE_BREAKPOINT);
                    pend_d     = pend_q & ~arb_gnt;
                    ptr_d      = (arb_idx == SRC_W'(NR_SOURCES - 1)) ? '0 : arb_idx + SRC_W'(1);
                    state_d    = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (flush_i) begin
                    clear_all = 1'b1;
                    state_d   = ST_IDLE;
                end else if (ex_ready_i) begin
                    drain_d = DRN_W'(DRAIN_CYCLES);
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (flush_i) begin
                    clear_all = 1'b1;
                    state_d   = ST_IDLE;
                end else if (drain_q <= DRN_W'(1)) begin
                    drain_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pend_d = clear_all ? '0 : (pend_d | new_req);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q     <= CFI_OFF;
            en_q       <= 1'b0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            pend_q     <= '0;
            ptr_q      <= '0;
            tval_q     <= '0;
            ex_tval_q  <= '0;
            ex_cause_q <= '0;
            ex_src_q   <= '0;
        end else begin
            if (csr_we_i) begin
                mode_q <= cfi_mode_e'(csr_wdata_i);
                en_q   <= |csr_wdata_i;
            end
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            state_q    <= state_d;
            drain_q    <= drain_d;
            pend_q     <= pend_d;
            ptr_q      <= ptr_d;
            tval_q     <= tval_d;
            ex_tval_q  <= ex_tval_d;
            ex_cause_q <= ex_cause_d;
            ex_src_q   <= ex_src_d;
        end
    end

    assign mode_o     = mode_q;
    assign csr_en_o   = en_q;
    assign viol_cnt_o = cnt_q;
    assign cnt_sat_o  = sat_q;
    assign ex_valid_o = (state_q == ST_REPORT);
    assign busy_o     = (state_q != ST_IDLE);
    assign ex_tval_o  = ex_tval_q;
    assign ex_cause_o = ex_cause_q;
    assign ex_src_o   = ex_src_q;

endmodule

// File: tb/tb_cfi_violation_ctrl.sv
// Directed bench for cfi_violation_ctrl: a vector table for the main flow and
// hand-written sequences for stall, async reset and counter saturation.
module tb_cfi_violation_ctrl;

    logic             clk = 1'b0;
    logic             rst;
    logic             csr_we;
    logic [1:0]       csr_wdata;
    logic [1:0]       src_req;
    logic [1:0][63:0] src_tval;
    logic             flush;
    logic             ex_ready;

    logic [1:0]  mode, mode4;
    logic        csr_en, csr_en4;
    logic        ex_valid, ex_valid4;
    logic [63:0] ex_cause, ex_cause4, ex_tval, ex_tval4;
    logic        ex_src, ex_src4;
    logic [15:0] viol_cnt;
    logic [3:0]  viol_cnt4;
    logic        cnt_sat, cnt_sat4, busy, busy4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cfi_violation_ctrl u_dut (
        .clk_i(clk), .rst_i(rst), .csr_we_i(csr_we), .csr_wdata_i(csr_wdata),
        .mode_o(mode), .csr_en_o(csr_en), .src_req_i(src_req), .src_tval_i(src_tval),
        .flush_i(flush), .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
        .ex_cause_o(ex_cause), .ex_tval_o(ex_tval), .ex_src_o(ex_src),
        .viol_cnt_o(viol_cnt), .cnt_sat_o(cnt_sat), .busy_o(busy)
    );

    cfi_violation_ctrl #(.CNT_WIDTH(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .csr_we_i(csr_we), .csr_wdata_i(csr_wdata),
        .mode_o(mode4), .csr_en_o(csr_en4), .src_req_i(src_req), .src_tval_i(src_tval),
        .flush_i(flush), .ex_valid_o(ex_valid4), .ex_ready_i(ex_ready),
        .ex_cause_o(ex_cause4), .ex_tval_o(ex_tval4), .ex_src_o(ex_src4),
        .viol_cnt_o(viol_cnt4), .cnt_sat_o(cnt_sat4), .busy_o(busy4)
    );

    typedef struct {
        logic        we;
        logic [1:0]  wdata;
        logic [1:0]  req;
        logic [63:0] t0;
        logic [63:0] t1;
        logic        flush;
        logic        ready;
        logic        e_valid;
        logic        e_src;
        logic [63:0] e_tval;
        logic [15:0] e_cnt;
        logic        e_busy;
        logic [1:0]  e_mode;
        logic        e_en;
    } vec_t;

    vec_t vt[32];

    function automatic vec_t mk(input logic we, input logic [1:0] wd, input logic [1:0] rq,
                                input logic [63:0] t0, input logic [63:0] t1,
                                input logic fl, input logic rd, input logic ev,
                                input logic es, input logic [63:0] et, input logic [15:0] ec,
                                input logic eb, input logic [1:0] em, input logic ee);
        vec_t v;
        v.we = we; v.wdata = wd; v.req = rq; v.t0 = t0; v.t1 = t1; v.flush = fl; v.ready = rd;
        v.e_valid = ev; v.e_src = es; v.e_tval = et; v.e_cnt = ec; v.e_busy = eb;
        v.e_mode = em; v.e_en = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        csr_we = 1'b0; csr_wdata = 2'd0; src_req = 2'b00;
        src_tval[0] = '0; src_tval[1] = '0; flush = 1'b0; ex_ready = 1'b0;
    endtask

    initial begin
        // we wd req t0 t1 fl rdy | valid src tval cnt busy mode en
        vt[0]  = mk(1, 2, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 1);
        vt[1]  = mk(0, 0, 2'b10, 0, 64'h8000_1234, 0, 1,  0, 0, 0, 1, 0, 2, 1);
        vt[2]  = mk(0, 0, 2'b00, 0, 0, 0, 1,  1, 1, 64'h8000_1234, 1, 1, 2, 1);
        vt[3]  = mk(0, 0, 2'b00, 0, 0, 0, 1,  0, 0, 0, 1, 1, 2, 1);
        vt[4]  = mk(0, 0, 2'b00, 0, 0, 1, 0,  0, 0, 0, 1, 0, 2, 1);
        vt[5]  = mk(0, 0, 2'b11, 64'h1000, 64'h2000, 0, 0,  0, 0, 0, 3, 0, 2, 1);
        vt[6]  = mk(0, 0, 2'b00, 0, 0, 0, 0,  1, 0, 64'h1000, 3, 1, 2, 1);
        vt[7]  = mk(0, 0, 2'b00, 0, 0, 0, 1,  0, 0, 0, 3, 1, 2, 1);
        vt[8]  = mk(0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 3, 1, 2, 1);
        vt[9]  = mk(0, 0, 2'b01, 64'hdead, 0, 0, 0,  0, 0, 0, 4, 1, 2, 1);
        vt[10] = mk(0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 4, 1, 2, 1);
        vt[11] = mk(0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 4, 0, 2, 1);
        vt[12] = mk(0, 0, 2'b00, 0, 0, 0, 0,  1, 1, 64'h2000, 4, 1, 2, 1);
        vt[13] = mk(0, 0, 2'b00, 0, 0, 0, 1,  0, 0, 0, 4, 1, 2, 1);
        vt[14] = mk(0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 4, 1, 2, 1);
        vt[15] = mk(0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 4, 1, 2, 1);
        vt[16] = mk(0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 4, 1, 2, 1);
        vt[17] = mk(0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 4, 0, 2, 1);
        vt[18] = mk(0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 4, 0, 2, 1);
        vt[19] = mk(1, 1, 2'b00, 0, 0, 0, 0,  0, 0, 0, 4, 0, 1, 1);
        vt[20] = mk(0, 0, 2'b01, 64'h11, 0, 0, 0,  0, 0, 0, 5, 0, 1, 1);
        vt[21] = mk(0, 0, 2'b10, 0, 64'h22, 0, 0,  0, 0, 0, 6, 0, 1, 1);
        vt[22] = mk(0, 0, 2'b01, 64'h33, 0, 0, 0,  0, 0, 0, 7, 0, 1, 1);
        vt[23] = mk(0, 0, 2'b10, 0, 64'h44, 0, 0,  0, 0, 0, 8, 0, 1, 1);
        vt[24] = mk(0, 0, 2'b01, 64'h55, 0, 0, 1,  0, 0, 0, 9, 0, 1, 1);
        vt[25] = mk(1, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 9, 0, 0, 0);
        vt[26] = mk(0, 0, 2'b11, 1, 2, 0, 0,  0, 0, 0, 9, 0, 0, 0);
        vt[27] = mk(0, 0, 2'b11, 1, 2, 0, 0,  0, 0, 0, 9, 0, 0, 0);
        vt[28] = mk(1, 3, 2'b00, 0, 0, 0, 0,  0, 0, 0, 9, 0, 3, 1);
        vt[29] = mk(0, 0, 2'b01, 64'h55, 0, 0, 0,  0, 0, 0, 10, 0, 3, 1);
        vt[30] = mk(0, 0, 2'b00, 0, 0, 0, 0,  1, 0, 64'h55, 10, 1, 3, 1);
        vt[31] = mk(0, 0, 2'b00, 0, 0, 1, 0,  0, 0, 0, 10, 0, 3, 1);

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_valid", ex_valid, 0);
        chk("reset_mode",  mode, 0);
        chk("reset_en",    csr_en, 0);
        chk("reset_cnt",   viol_cnt, 0);
        chk("reset_sat",   cnt_sat, 0);
        chk("reset_busy",  busy, 0);
        chk("reset_tval",  ex_tval, 0);
        chk("reset_cause", ex_cause, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) begin
            csr_we = vt[i].we; csr_wdata = vt[i].wdata; src_req = vt[i].req;
            src_tval[0] = vt[i].t0; src_tval[1] = vt[i].t1;
            flush = vt[i].flush; ex_ready = vt[i].ready;
            step();
            chk($sformatf("v%0d_valid", i), ex_valid, vt[i].e_valid);
            chk($sformatf("v%0d_cnt", i),   viol_cnt, vt[i].e_cnt);
            chk($sformatf("v%0d_busy", i),  busy, vt[i].e_busy);
            chk($sformatf("v%0d_mode", i),  mode, vt[i].e_mode);
            chk($sformatf("v%0d_en", i),    csr_en, vt[i].e_en);
            chk($sformatf("v%0d_sat", i),   cnt_sat, 0);
            if (vt[i].e_valid) begin
                chk($sformatf("v%0d_src", i),   ex_src, vt[i].e_src);
                chk($sformatf("v%0d_tval", i),  ex_tval, vt[i].e_tval);
                chk($sformatf("v%0d_cause", i), ex_cause, 64'd3);
            end
        end
        idle_inputs();

        // Stalled report: outputs hold, mode write does not abort, flush clears pending.
        src_req = 2'b01; src_tval[0] = 64'habc;
        step();
        idle_inputs();
        step();
        chk("stall_start_valid", ex_valid, 1);
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            if (c == 3) begin src_req = 2'b10; src_tval[1] = 64'h777; end
            if (c == 5) begin csr_we = 1'b1; csr_wdata = 2'd0; end
            step();
            chk($sformatf("stall%0d_valid", c), ex_valid, 1);
            chk($sformatf("stall%0d_tval", c),  ex_tval, 64'habc);
            chk($sformatf("stall%0d_src", c),   ex_src, 0);
            chk($sformatf("stall%0d_cause", c), ex_cause, 64'd3);
        end
        chk("stall_cnt", viol_cnt, 12);
        chk("stall_mode", mode, 0);
        idle_inputs();
        flush = 1'b1;
        step();
        chk("stall_flush_valid", ex_valid, 0);
        chk("stall_flush_busy",  busy, 0);
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall_post%0d_valid", c), ex_valid, 0);
            chk($sformatf("stall_post%0d_busy", c),  busy, 0);
        end

        // Asynchronous reset in the middle of a report.
        csr_we = 1'b1; csr_wdata = 2'd2;
        step();
        idle_inputs();
        src_req = 2'b10; src_tval[1] = 64'h99;
        step();
        idle_inputs();
        step();
        chk("arst_pre_valid", ex_valid, 1);
        chk("arst_pre_tval",  ex_tval, 64'h99);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_mode",  mode, 0);
        chk("arst_cnt",   viol_cnt, 0);
        chk("arst_busy",  busy, 0);
        chk("arst_en",    csr_en, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("arst_post%0d_valid", c), ex_valid, 0);
            chk($sformatf("arst_post%0d_busy", c),  busy, 0);
        end

        // Saturation on the 4-bit counter instance, 20 pulses in COUNT mode.
        csr_we = 1'b1; csr_wdata = 2'd1;
        step();
        idle_inputs();
        src_req = 2'b11;
        repeat (7) step();
        chk("sat_mid_cnt4", viol_cnt4, 14);
        chk("sat_mid_sat4", cnt_sat4, 0);
        repeat (3) step();
        chk("sat_cnt4",  viol_cnt4, 15);
        chk("sat_sat4",  cnt_sat4, 1);
        chk("sat_cnt16", viol_cnt, 20);
        chk("sat_sat16", cnt_sat, 0);
        chk("sat_valid", ex_valid, 0);
        src_req = 2'b01;
        step();
        idle_inputs();
        step();
        chk("sat_hold_cnt4", viol_cnt4, 15);
        chk("sat_hold_sat4", cnt_sat4, 1);
        chk("sat_hold_cnt16", viol_cnt, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
